// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arbiter_pkg;

  // Arbiter session state: normal round-robin sharing, or loader-exclusive.
  typedef enum logic {
    StRun  = 1'b0,
    StLock = 1'b1
  } arb_state_e;

  // Reset value of the fetched instruction (addi x0, x0, 0).
  localparam logic [31:0] InstNop = 32'h0000_0013;

  // Default memory depth in 32-bit words.
  localparam int unsigned MemWordsDefault = 16384;

  // Round-robin pointer encoding: which requester is preferred on contention.
  localparam logic PtrFetch  = 1'b0;
  localparam logic PtrLoader = 1'b1;

endpackage

// File: rtl/imem_rr_pick.sv
// Two-way round-robin picker. Purely combinational; the owner of the pointer
// updates it from the grants.
module imem_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,   // 0: req0 preferred on contention, 1: req1 preferred
  output logic gnt0,
  output logic gnt1
);

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = ~ptr;
      gnt1 = ptr;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter between the fetch stage (read-only)
// and the program loader (read/write), with a loader lock that holds the core.
// Optional feature macro: IMEM_ARB_BOUNDS_CHK_EN enables misaligned / out-of-range
// detection; without it, f_err/l_err are tied low and addresses wrap.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MemWordsDefault,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // Fetch port
  input  logic          f_req,
  input  logic [AW-1:0] f_pc,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [31:0]   f_inst,
  output logic          f_err,
  // Loader port
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_valid,
  output logic [31:0]   l_rdata,
  output logic          l_err,
  output logic [15:0]   l_wcount,
  output logic          cpu_hold,
  // Memory port
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam int unsigned WW = AW - 2;
  localparam logic [WW-1:0] MemWordsW = WW'(MEM_WORDS);

  arb_state_e    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          rr_f_gnt, rr_l_gnt;

  logic [WW-1:0] f_word, l_word;
  logic          f_bad, l_bad;

  logic [AW-1:0] m_addr_q, m_addr_d;

  logic          f_valid_q, f_valid_d;
  logic          f_err_q, f_err_d;
  logic [31:0]   f_inst_q, f_inst_d;
  logic          l_valid_q, l_valid_d;
  logic          l_err_q, l_err_d;
  logic [31:0]   l_rdata_q, l_rdata_d;
  logic [15:0]   wcount_q, wcount_d;

  assign f_word = f_pc[AW-1:2];
  assign l_word = l_addr[AW-1:2];

`ifdef IMEM_ARB_BOUNDS_CHK_EN
  // Faulty accesses are still granted but never touch the memory.
  assign f_bad = (f_pc[1:0] != 2'b00) || (f_word >= MemWordsW);
  assign l_bad = (l_addr[1:0] != 2'b00) || (l_word >= MemWordsW);
`else
  assign f_bad = 1'b0;
  assign l_bad = 1'b0;
`endif

  // Byte-lane bits only matter when bounds checking is compiled in.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{f_pc[1:0], l_addr[1:0]};

  imem_rr_pick u_rr_pick (
    .req0 (f_req),
    .req1 (l_req),
    .ptr  (ptr_q),
    .gnt0 (rr_f_gnt),
    .gnt1 (rr_l_gnt)
  );

  // FSM next state and grants; l_lock overrides arbitration in either state.
  always_comb begin
    state_d = state_q;
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    case (state_q)
      StRun: begin
        if (l_lock) begin
          state_d = StLock;
          l_gnt   = l_req;
        end else begin
          f_gnt = rr_f_gnt;
          l_gnt = rr_l_gnt;
        end
      end
      StLock: begin
        // Fetch stays blocked for the whole LOCK cycle, even as the lock drops.
        l_gnt = l_req;
        if (!l_lock) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Pointer points away from whoever won most recently.
  always_comb begin
    ptr_d = ptr_q;
    if (f_gnt) begin
      ptr_d = PtrLoader;
    end else if (l_gnt) begin
      ptr_d = PtrFetch;
    end
  end

  // Memory address mux: winner's word address, wrapped to depth; held when idle.
  always_comb begin
    m_addr_d = m_addr_q;
    if (f_gnt) begin
      m_addr_d = {f_word % MemWordsW, 2'b00};
    end else if (l_gnt) begin
      m_addr_d = {l_word % MemWordsW, 2'b00};
    end
  end

  assign m_addr  = m_addr_d;
  // rst_n gating keeps a write granted during reset from corrupting memory.
  assign m_we    = l_gnt & l_we & ~l_bad & rst_n;
  assign m_wdata = l_wdata;

  // Response capture: one-cycle valid pulses, data held between accesses.
  always_comb begin
    f_valid_d = f_gnt;
    f_err_d   = f_gnt & f_bad;
    f_inst_d  = f_inst_q;
    if (f_gnt) begin
      f_inst_d = f_bad ? 32'h0 : m_rdata;
    end

    l_valid_d = l_gnt;
    l_err_d   = l_gnt & l_bad;
    l_rdata_d = l_rdata_q;
    if (l_gnt && l_bad) begin
      l_rdata_d = 32'h0;
    end else if (l_gnt && !l_we) begin
      l_rdata_d = m_rdata;
    end

    wcount_d = wcount_q;
    if (m_we && (wcount_q != 16'hFFFF)) begin
      wcount_d = wcount_q + 16'd1;
    end
  end

  // State, pointer and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRun;
      ptr_q     <= PtrFetch;
      m_addr_q  <= '0;
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
      f_inst_q  <= InstNop;
      l_valid_q <= 1'b0;
      l_err_q   <= 1'b0;
      l_rdata_q <= 32'h0;
      wcount_q  <= 16'h0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      m_addr_q  <= m_addr_d;
      f_valid_q <= f_valid_d;
      f_err_q   <= f_err_d;
      f_inst_q  <= f_inst_d;
      l_valid_q <= l_valid_d;
      l_err_q   <= l_err_d;
      l_rdata_q <= l_rdata_d;
      wcount_q  <= wcount_d;
    end
  end

  // A response pending when reset asserts is dropped immediately.
  assign f_valid  = f_valid_q & rst_n;
  assign l_valid  = l_valid_q & rst_n;
  assign f_inst   = f_inst_q;
  assign l_rdata  = l_rdata_q;
  assign l_wcount = wcount_q;
  assign cpu_hold = (state_q == StLock);

`ifdef IMEM_ARB_BOUNDS_CHK_EN
  assign f_err = f_err_q & rst_n;
  assign l_err = l_err_q & rst_n;
`else
  assign f_err = 1'b0;
  assign l_err = 1'b0;
  logic unused_err;
  assign unused_err = f_err_q ^ l_err_q;
`endif

endmodule
